mem_arbiter_rr: RTL and testbench

- Parametrised N-channel arbiter that shares one slow-memory port among several cache refill/write-back ports (I-cache, D-cache, future extra caches).
- Each channel speaks the cache-to-memory protocol: a request is held until ready, and the data word is 128 bits, addressed by [31:4].
- Sits between the cache instances and a single memory, replacing separate per-cache memory ports.
- Supports round-robin or fixed-priority grant and registers the full request/response path.

---
 rtl/mem_arbiter_rr.sv | 133 +++++++++++++
 tb/tb_mem_arbiter_rr.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter sharing one slow-memory line port among cache refill/write-back ports.
// One transaction at a time: IDLE picks a winner, BUSY waits on the memory, RESP pulses ch_ready.
module mem_arbiter_rr #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter bit RR_EN  = 1'b1
) (
   input  logic                     clk,
   input  logic                     proc_reset,
   input  logic [NUM_CH-1:0]        ch_read,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ready,
   output logic [1:0]               fsm_state
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   last;
   logic [IDX_W-1:0]   grant;
   logic [NUM_CH-1:0]  req;

   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic               win_wr;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_wdata;

   assign req       = ch_read | ch_write;
   assign fsm_state = state;

   // Scan NUM_CH slots starting just after the last grant (or at 0 for fixed priority);
   // the first requester found wins. A channel holding read and write issues the write.
   always_comb begin : pick_winner
      int               j;
      logic [IDX_W-1:0] jj;
      j         = 0;
      jj        = '0;
      win_vld   = 1'b0;
      win_idx   = '0;
      win_wr    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (RR_EN) begin
            j = int'(last) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
         end else begin
            j = k - 1;
         end
         jj = IDX_W'(j);
         if (!win_vld && req[jj]) begin
            win_vld   = 1'b1;
            win_idx   = jj;
            win_wr    = ch_write[jj];
            win_addr  = ch_addr[j*ADDR_W +: ADDR_W];
            win_wdata = ch_wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state     <= IDLE;
         last      <= IDX_W'(NUM_CH - 1);
         grant     <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ch_ready  <= '0;
         ch_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  grant     <= win_idx;
                  mem_read  <= ~win_wr;
                  mem_write <= win_wr;
                  mem_addr  <= win_addr;
                  mem_wdata <= win_wdata;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               // No timeout: the memory is trusted to answer every strobe.
               if (mem_ready) begin
                  ch_rdata  <= mem_rdata;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  ch_ready  <= NUM_CH'(1) << grant;
                  state     <= RESP;
               end
            end
            RESP: begin
               ch_ready <= '0;
               if (RR_EN) last <= grant;
               state <= IDLE;
            end
            default: begin
               ch_ready  <= '0;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   a_strobe_excl: assert property (@(posedge clk) disable iff (proc_reset)
      !(mem_read && mem_write));
   a_ready_onehot: assert property (@(posedge clk) disable iff (proc_reset)
      $onehot0(ch_ready));
   a_strobe_busy_only: assert property (@(posedge clk) disable iff (proc_reset)
      (mem_read || mem_write) |-> (state == BUSY));

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a cycle table on a 2-channel round-robin instance,
// plus grant-order sequences on a fixed-priority 2-channel and a round-robin 4-channel instance.
module tb_mem_arbiter_rr;

   logic clk;
   logic proc_reset;

   // instance a: NUM_CH=2, RR_EN=1
   logic [1:0]   a_ch_read, a_ch_write, a_ch_ready;
   logic [55:0]  a_ch_addr;
   logic [255:0] a_ch_wdata;
   logic [127:0] a_ch_rdata, a_mem_wdata, a_mem_rdata;
   logic         a_mem_read, a_mem_write, a_mem_ready;
   logic [27:0]  a_mem_addr;
   logic [1:0]   a_fsm_state;

   // instance b: NUM_CH=2, RR_EN=0
   logic [1:0]   b_ch_read, b_ch_write, b_ch_ready;
   logic [55:0]  b_ch_addr;
   logic [255:0] b_ch_wdata;
   logic [127:0] b_ch_rdata, b_mem_wdata, b_mem_rdata;
   logic         b_mem_read, b_mem_write, b_mem_ready;
   logic [27:0]  b_mem_addr;
   logic [1:0]   b_fsm_state;

   // instance c: NUM_CH=4, RR_EN=1
   logic [3:0]   c_ch_read, c_ch_write, c_ch_ready;
   logic [111:0] c_ch_addr;
   logic [511:0] c_ch_wdata;
   logic [127:0] c_ch_rdata, c_mem_wdata, c_mem_rdata;
   logic         c_mem_read, c_mem_write, c_mem_ready;
   logic [27:0]  c_mem_addr;
   logic [1:0]   c_fsm_state;

   mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(28), .DATA_W(128), .RR_EN(1'b1)) u_a (
      .clk(clk), .proc_reset(proc_reset),
      .ch_read(a_ch_read), .ch_write(a_ch_write), .ch_addr(a_ch_addr), .ch_wdata(a_ch_wdata),
      .ch_rdata(a_ch_rdata), .ch_ready(a_ch_ready),
      .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready),
      .fsm_state(a_fsm_state)
   );

   mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(28), .DATA_W(128), .RR_EN(1'b0)) u_b (
      .clk(clk), .proc_reset(proc_reset),
      .ch_read(b_ch_read), .ch_write(b_ch_write), .ch_addr(b_ch_addr), .ch_wdata(b_ch_wdata),
      .ch_rdata(b_ch_rdata), .ch_ready(b_ch_ready),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
      .fsm_state(b_fsm_state)
   );

   mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(28), .DATA_W(128), .RR_EN(1'b1)) u_c (
      .clk(clk), .proc_reset(proc_reset),
      .ch_read(c_ch_read), .ch_write(c_ch_write), .ch_addr(c_ch_addr), .ch_wdata(c_ch_wdata),
      .ch_rdata(c_ch_rdata), .ch_ready(c_ch_ready),
      .mem_read(c_mem_read), .mem_write(c_mem_write), .mem_addr(c_mem_addr),
      .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata), .mem_ready(c_mem_ready),
      .fsm_state(c_fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [3:0]  exp_q[$];

   localparam logic [27:0]  A0 = 28'h0000123;
   localparam logic [27:0]  A1 = 28'h0000456;
   localparam logic [127:0] W0 = 128'hFEDCBA98765432100011223344556677;
   localparam logic [127:0] W1 = 128'h0123456789ABCDEF0123456789ABCDEF;

   task automatic chk(input string name, input int idx, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
      end
   endtask

   // ---------------- vector table for instance a ----------------
   typedef struct {
      logic       rst;
      logic [1:0] rd;
      logic [1:0] wr;
      logic       mrdy;
      logic [7:0] mbyte;
      logic       e_mrd;
      logic       e_mwr;
      logic       e_ch;
      logic [1:0] e_rdy;
      logic [7:0] e_rbyte;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                               input logic mrdy, input logic [7:0] mbyte, input logic e_mrd,
                               input logic e_mwr, input logic e_ch, input logic [1:0] e_rdy,
                               input logic [7:0] e_rbyte);
      vec_t v;
      v.rst = rst; v.rd = rd; v.wr = wr; v.mrdy = mrdy; v.mbyte = mbyte;
      v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_ch = e_ch; v.e_rdy = e_rdy; v.e_rbyte = e_rbyte;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   // One transaction on instance b (sel=0) or c (sel=1): wait for the strobe, answer it,
   // and compare the granted channel against the head of exp_q.
   task automatic txn(input int sel, input string tag);
      logic [3:0]   exp_g;
      logic         strobe;
      logic [27:0]  addr;
      logic [3:0]   rdy;
      logic [127:0] rdata;
      int           n;
      exp_g  = exp_q.pop_front();
      n      = 0;
      strobe = (sel == 0) ? b_mem_read : c_mem_read;
      while (!strobe && n < 20) begin
         @(posedge clk); #1;
         n++;
         strobe = (sel == 0) ? b_mem_read : c_mem_read;
      end
      chk({tag, "_strobe"}, n, 128'(strobe), 128'(1'b1));
      addr = (sel == 0) ? b_mem_addr : c_mem_addr;
      chk({tag, "_addr"}, int'(exp_g), 128'(addr), 128'(28'h1000 + 28'(exp_g)));
      if (sel == 0) begin
         b_mem_rdata = {32{exp_g}};
         b_mem_ready = 1'b1;
      end else begin
         c_mem_rdata = {32{exp_g}};
         c_mem_ready = 1'b1;
      end
      @(posedge clk); #1;
      b_mem_ready = 1'b0;
      c_mem_ready = 1'b0;
      rdy   = (sel == 0) ? {2'b00, b_ch_ready} : c_ch_ready;
      rdata = (sel == 0) ? b_ch_rdata : c_ch_rdata;
      chk({tag, "_ready"}, int'(exp_g), 128'(rdy), 128'(4'b0001 << exp_g));
      chk({tag, "_rdata"}, int'(exp_g), rdata, {32{exp_g}});
   endtask

   // ---------------- test ----------------
   initial begin
      proc_reset  = 1'b1;
      a_ch_read   = '0; a_ch_write = '0; a_mem_ready = 1'b0; a_mem_rdata = '0;
      a_ch_addr   = {A1, A0};
      a_ch_wdata  = {W1, W0};
      b_ch_read   = '0; b_ch_write = '0; b_mem_ready = 1'b0; b_mem_rdata = '0;
      b_ch_addr   = {28'h1001, 28'h1000};
      b_ch_wdata  = '0;
      c_ch_read   = '0; c_ch_write = '0; c_mem_ready = 1'b0; c_mem_rdata = '0;
      c_ch_addr   = {28'h1003, 28'h1002, 28'h1001, 28'h1000};
      c_ch_wdata  = '0;

      //                rst rd     wr     rdy mbyte  mrd  mwr  ch   e_rdy  e_rbyte
      vecs.push_back(mk(1, 2'b00, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h00)); // reset
      vecs.push_back(mk(0, 2'b00, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h00));
      vecs.push_back(mk(0, 2'b01, 2'b00, 0, 8'h00, 1,   0,   0,   2'b00, 8'h00)); // read ch0
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 2'b01, 2'b00, 0, 8'h00, 1, 0, 0, 2'b00, 8'h00));
      vecs.push_back(mk(0, 2'b01, 2'b00, 1, 8'hA5, 0,   0,   0,   2'b01, 8'hA5));
      vecs.push_back(mk(0, 2'b00, 2'b00, 0, 8'h3C, 0,   0,   0,   2'b00, 8'hA5)); // rdata held
      vecs.push_back(mk(0, 2'b00, 2'b10, 0, 8'h00, 0,   1,   1,   2'b00, 8'hA5)); // write ch1
      vecs.push_back(mk(0, 2'b00, 2'b10, 0, 8'h00, 0,   1,   1,   2'b00, 8'hA5));
      vecs.push_back(mk(0, 2'b00, 2'b10, 1, 8'h77, 0,   0,   0,   2'b10, 8'h77));
      vecs.push_back(mk(0, 2'b00, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h77));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 8'h00, 1,   0,   0,   2'b00, 8'h77)); // contention
      vecs.push_back(mk(0, 2'b11, 2'b00, 1, 8'h11, 0,   0,   0,   2'b01, 8'h11));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h11));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 8'h00, 1,   0,   1,   2'b00, 8'h11));
      vecs.push_back(mk(0, 2'b11, 2'b00, 1, 8'h22, 0,   0,   0,   2'b10, 8'h22));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h22));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 8'h00, 1,   0,   0,   2'b00, 8'h22));
      vecs.push_back(mk(0, 2'b11, 2'b00, 1, 8'h33, 0,   0,   0,   2'b01, 8'h33));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h33));
      vecs.push_back(mk(0, 2'b11, 2'b00, 0, 8'h00, 1,   0,   1,   2'b00, 8'h33));
      vecs.push_back(mk(0, 2'b11, 2'b00, 1, 8'h44, 0,   0,   0,   2'b10, 8'h44));
      vecs.push_back(mk(0, 2'b00, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h44));
      vecs.push_back(mk(0, 2'b01, 2'b01, 0, 8'h00, 0,   1,   0,   2'b00, 8'h44)); // rd+wr: write
      vecs.push_back(mk(0, 2'b01, 2'b01, 1, 8'h55, 0,   0,   0,   2'b01, 8'h55));
      vecs.push_back(mk(0, 2'b00, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h55));
      vecs.push_back(mk(0, 2'b10, 2'b00, 0, 8'h00, 1,   0,   1,   2'b00, 8'h55)); // busy ch1
      vecs.push_back(mk(1, 2'b10, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h00)); // reset mid-busy
      vecs.push_back(mk(0, 2'b00, 2'b00, 1, 8'h99, 0,   0,   0,   2'b00, 8'h00)); // stray ready
      vecs.push_back(mk(0, 2'b01, 2'b00, 0, 8'h00, 1,   0,   0,   2'b00, 8'h00));
      vecs.push_back(mk(0, 2'b01, 2'b00, 1, 8'h66, 0,   0,   0,   2'b01, 8'h66));
      vecs.push_back(mk(0, 2'b00, 2'b00, 0, 8'h00, 0,   0,   0,   2'b00, 8'h66));

      foreach (vecs[i]) begin
         proc_reset  = vecs[i].rst;
         a_ch_read   = vecs[i].rd;
         a_ch_write  = vecs[i].wr;
         a_mem_ready = vecs[i].mrdy;
         a_mem_rdata = {16{vecs[i].mbyte}};
         @(posedge clk); #1;
         chk("mem_read",  i, 128'(a_mem_read),  128'(vecs[i].e_mrd));
         chk("mem_write", i, 128'(a_mem_write), 128'(vecs[i].e_mwr));
         chk("ch_ready",  i, 128'(a_ch_ready),  128'(vecs[i].e_rdy));
         chk("ch_rdata",  i, a_ch_rdata, {16{vecs[i].e_rbyte}});
         if (vecs[i].e_mrd || vecs[i].e_mwr)
            chk("mem_addr", i, 128'(a_mem_addr), 128'(vecs[i].e_ch ? A1 : A0));
         if (vecs[i].e_mwr)
            chk("mem_wdata", i, a_mem_wdata, vecs[i].e_ch ? W1 : W0);
         if (vecs[i].rst)
            chk("fsm_state", i, 128'(a_fsm_state), 128'(2'd0));
      end
      a_ch_read   = '0;
      a_ch_write  = '0;
      a_mem_ready = 1'b0;

      // Fixed priority: ch0 wins every time while it holds; ch1 only once ch0 drops.
      b_ch_read = 2'b11;
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd0);
      txn(0, "fp_a");
      txn(0, "fp_b");
      txn(0, "fp_c");
      b_ch_read = 2'b10;
      exp_q.push_back(4'd1);
      txn(0, "fp_d");
      b_ch_read = 2'b00;

      // Wrap-around on 4 channels from last=3: requests on 1 and 3 alternate 1,3,1.
      c_ch_read = 4'b1010;
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd3);
      exp_q.push_back(4'd1);
      txn(1, "wrap_a");
      txn(1, "wrap_b");
      txn(1, "wrap_c");
      c_ch_read = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("wrap_idle", 0, 128'(c_mem_read), 128'(1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
